// File: rtl/reg_writeback_ctrl_if.sv
// Register-file writeback bus: ALU result port, load handshake port and the
// merged destination write port with its hazard/idle status.
interface reg_writeback_ctrl_if #(
  parameter int WORD_BITS     = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int NUM_OF_REG    = 32
);
  logic                     iAluValid;
  logic [REG_ADDR_BITS-1:0] iAluAddr;
  logic [WORD_BITS-1:0]     iAluVal;
  logic                     oAluStall;
  logic                     iLdValid;
  logic                     oLdReady;
  logic [REG_ADDR_BITS-1:0] iLdAddr;
  logic [WORD_BITS-1:0]     iLdVal;
  logic [REG_ADDR_BITS-1:0] oDstAddr;
  logic [WORD_BITS-1:0]     oDstVal;
  logic                     oDstValid;
  logic [NUM_OF_REG-1:0]    oBusyMask;
  logic                     oIdle;

  modport master (
    output iAluValid, iAluAddr, iAluVal, iLdValid, iLdAddr, iLdVal,
    input  oAluStall, oLdReady, oDstAddr, oDstVal, oDstValid, oBusyMask, oIdle
  );

  modport slave (
    input  iAluValid, iAluAddr, iAluVal, iLdValid, iLdAddr, iLdVal,
    output oAluStall, oLdReady, oDstAddr, oDstVal, oDstValid, oBusyMask, oIdle
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Merges ALU results (priority, unbuffered) and buffered load results into the
// single register-file write port; publishes pending-write mask and idle flag.
module reg_writeback_ctrl #(
  parameter int WORD_BITS     = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int NUM_OF_REG    = 32,
  parameter int LD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input logic                 clk,
  input logic                 rst,
  reg_writeback_ctrl_if.slave bus
);
  localparam int PTR_BITS    = $clog2(LD_FIFO_DEPTH);
  localparam int CNT_BITS    = PTR_BITS + 1;
  localparam int STARVE_BITS = $clog2(STARVE_LIMIT + 1);

  logic [PTR_BITS-1:0]      rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CNT_BITS-1:0]      count_q, count_d;
  logic [STARVE_BITS-1:0]   starve_q, starve_d;
  logic [REG_ADDR_BITS-1:0] addrMem_q [LD_FIFO_DEPTH];
  logic [WORD_BITS-1:0]     valMem_q  [LD_FIFO_DEPTH];
  logic [REG_ADDR_BITS-1:0] dstAddr_q, dstAddr_d;
  logic [WORD_BITS-1:0]     dstVal_q, dstVal_d;
  logic                     dstValid_q, dstValid_d;

  logic                  nonEmpty, forceDrain, ldReady, push, pop, aluWin;
  logic [PTR_BITS-1:0]   slotOff;
  logic [NUM_OF_REG-1:0] busyMask;

  // A forced drain overrides the ALU so a queued load cannot starve forever.
  always_comb begin
    nonEmpty   = (count_q != '0);
    forceDrain = nonEmpty && (starve_q == STARVE_BITS'(STARVE_LIMIT));
    ldReady    = rst && (count_q < CNT_BITS'(LD_FIFO_DEPTH));
    push       = bus.iLdValid && ldReady && (bus.iLdAddr != '0);
    pop        = forceDrain || (!bus.iAluValid && nonEmpty);
    aluWin     = !forceDrain && bus.iAluValid;

    dstValid_d = 1'b0;
    dstAddr_d  = dstAddr_q;
    dstVal_d   = dstVal_q;
    if (pop) begin
      dstValid_d = 1'b1;
      dstAddr_d  = addrMem_q[rdPtr_q];
      dstVal_d   = valMem_q[rdPtr_q];
    end else if (aluWin && (bus.iAluAddr != '0)) begin
      dstValid_d = 1'b1;
      dstAddr_d  = bus.iAluAddr;
      dstVal_d   = bus.iAluVal;
    end

    rdPtr_d = rdPtr_q + PTR_BITS'(pop);
    wrPtr_d = wrPtr_q + PTR_BITS'(push);
    count_d = count_q + CNT_BITS'(push) - CNT_BITS'(pop);

    starve_d = starve_q;
    if (pop || !nonEmpty) begin
      starve_d = '0;
    end else if (aluWin && (starve_q != STARVE_BITS'(STARVE_LIMIT))) begin
      starve_d = starve_q + STARVE_BITS'(1);
    end
  end

  // Slots between the read pointer and read pointer + count hold live entries.
  always_comb begin
    busyMask = '0;
    slotOff  = '0;
    for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
      slotOff = PTR_BITS'(i) - rdPtr_q;
      if ({1'b0, slotOff} < count_q) begin
        busyMask[addrMem_q[i]] = 1'b1;
      end
    end
    if (dstValid_q) begin
      busyMask[dstAddr_q] = 1'b1;
    end
    busyMask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      dstAddr_q  <= '0;
      dstVal_q   <= '0;
      dstValid_q <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      dstAddr_q  <= dstAddr_d;
      dstVal_q   <= dstVal_d;
      dstValid_q <= dstValid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addrMem_q[wrPtr_q] <= bus.iLdAddr;
      valMem_q[wrPtr_q]  <= bus.iLdVal;
    end
  end

  assign bus.oLdReady  = ldReady;
  assign bus.oAluStall = rst && forceDrain && bus.iAluValid;
  assign bus.oDstAddr  = dstAddr_q;
  assign bus.oDstVal   = dstVal_q;
  assign bus.oDstValid = dstValid_q;
  assign bus.oBusyMask = busyMask;
  assign bus.oIdle     = (count_q == '0) && !dstValid_q;
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: expected writes are queued as stimulus
// is issued and a negedge monitor retires them against the write port.
module tb_reg_writeback_ctrl;
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] val;
  } wr_t;

  logic clk;
  logic rst;
  int   asserts;
  int   failures;
  wr_t  expQ[$];

  reg_writeback_ctrl_if #(.WORD_BITS(32), .REG_ADDR_BITS(5), .NUM_OF_REG(32)) bus ();

  reg_writeback_ctrl #(
    .WORD_BITS(32), .REG_ADDR_BITS(5), .NUM_OF_REG(32),
    .LD_FIFO_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic aluV, input logic [4:0] aluA, input logic [31:0] aluD,
                               input logic ldV, input logic [4:0] ldA, input logic [31:0] ldD);
    @(posedge clk);
    #1;
    bus.iAluValid = aluV;
    bus.iAluAddr  = aluA;
    bus.iAluVal   = aluD;
    bus.iLdValid  = ldV;
    bus.iLdAddr   = ldA;
    bus.iLdVal    = ldD;
  endtask

  // Every asserted write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.oDstValid === 1'b1) begin
      if (expQ.size() == 0) begin
        asserts++;
        failures++;
        $display("[TB] FAIL unexpected_write: got addr %0d val 0x%0h, expected no write", bus.oDstAddr, bus.oDstVal);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("wr_addr", 32'(bus.oDstAddr), 32'(e.addr));
        checkOutput("wr_val", bus.oDstVal, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    asserts  = 0;
    failures = 0;
    rst = 1'b0;
    bus.iAluValid = 1'b1; bus.iAluAddr = 5'd9; bus.iAluVal = 32'h99;
    bus.iLdValid  = 1'b1; bus.iLdAddr  = 5'd3; bus.iLdVal  = 32'h33;

    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rst_ldReady", 32'(bus.oLdReady), 32'd0);
      checkOutput("rst_aluStall", 32'(bus.oAluStall), 32'd0);
      checkOutput("rst_dstValid", 32'(bus.oDstValid), 32'd0);
      checkOutput("rst_busyMask", bus.oBusyMask, 32'd0);
      checkOutput("rst_idle", 32'(bus.oIdle), 32'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.iAluValid = 1'b0; bus.iAluAddr = '0; bus.iAluVal = '0;
    bus.iLdValid  = 1'b0; bus.iLdAddr  = '0; bus.iLdVal  = '0;
    @(negedge clk);
    checkOutput("rel_ldReady", 32'(bus.oLdReady), 32'd1);
    checkOutput("rel_idle", 32'(bus.oIdle), 32'd1);

    // Single ALU write, latency one.
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    expQ.push_back('{5'd5, 32'h1234});
    @(negedge clk);
    checkOutput("alu_stall", 32'(bus.oAluStall), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("alu_dstValid", 32'(bus.oDstValid), 32'd1);
    checkOutput("alu_busyMask", bus.oBusyMask, 32'h0000_0020);
    checkOutput("alu_idle_busy", 32'(bus.oIdle), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("alu_idle_after", 32'(bus.oIdle), 32'd1);
    checkOutput("alu_busy_after", bus.oBusyMask, 32'd0);

    // Fill the load FIFO while the ALU owns the port every cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 5'(10 + i), 32'(32'hA0 + i), 1'b1, 5'(1 + i), 32'(32'h100 + i));
      expQ.push_back('{5'(10 + i), 32'(32'hA0 + i)});
      @(negedge clk);
      checkOutput("fill_ldReady", 32'(bus.oLdReady), (i < 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) expQ.push_back('{5'(1 + i), 32'(32'h100 + i)});
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("fill_busyMask", bus.oBusyMask, 32'h0000_401E);
    checkOutput("drain_ldReady_full", 32'(bus.oLdReady), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("drain_ldReady_open", 32'(bus.oLdReady), 32'd1);
    repeat (5) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("drain_idle", 32'(bus.oIdle), 32'd1);

    // One load against a continuously valid ALU forces a drain after 8 wins.
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b1, 5'(16 + j), 32'(32'hC00 + j), (j == 0), 5'd7, 32'h777);
      if (j < 9) begin
        expQ.push_back('{5'(16 + j), 32'(32'hC00 + j)});
      end else begin
        expQ.push_back('{5'd7, 32'h777});
        expQ.push_back('{5'd25, 32'hC09});
      end
      @(negedge clk);
      checkOutput("starve_stall", 32'(bus.oAluStall), (j == 9) ? 32'd1 : 32'd0);
      if (j == 9) checkOutput("starve_busyMask", bus.oBusyMask, 32'h0100_0080);
    end
    applyStimulus(1'b1, 5'd25, 32'hC09, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("starve_held_stall", 32'(bus.oAluStall), 32'd0);
    repeat (4) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("starve_idle", 32'(bus.oIdle), 32'd1);

    // Register 0 is never written from either source.
    applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hFFFF);
    @(negedge clk);
    checkOutput("r0_ldReady", 32'(bus.oLdReady), 32'd1);
    checkOutput("r0_stall", 32'(bus.oAluStall), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF);
    @(negedge clk);
    checkOutput("r0_dstValid", 32'(bus.oDstValid), 32'd0);
    checkOutput("r0_idle", 32'(bus.oIdle), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("r0_dstValid2", 32'(bus.oDstValid), 32'd0);
    checkOutput("r0_idle2", 32'(bus.oIdle), 32'd1);
    checkOutput("r0_busyMask", bus.oBusyMask, 32'd0);

    // Reset with loads queued discards them.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'(11 + i), 32'(32'hB0 + i), 1'b1, 5'(2 + i), 32'(32'h200 + i));
      expQ.push_back('{5'(11 + i), 32'(32'hB0 + i)});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.iAluValid = 1'b0; bus.iLdValid = 1'b0;
    @(negedge clk);
    checkOutput("mid_ldReady", 32'(bus.oLdReady), 32'd0);
    checkOutput("mid_busy_before", bus.oBusyMask, 32'h0000_201C);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_dstValid", 32'(bus.oDstValid), 32'd0);
    checkOutput("mid_busyMask", bus.oBusyMask, 32'd0);
    checkOutput("mid_idle", 32'(bus.oIdle), 32'd1);
    repeat (8) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Write-side controller for the CPU register file: the producer end of its destination write port (dst address/value/valid).
- Merges two result sources into the single register-file write port:
  - ALU results: priority, one per cycle, no buffering.
  - Load results: valid/ready handshake, buffered in a small FIFO.
- Publishes a per-register pending-write mask for decode hazard stalls, plus an idle flag that gates front/shadow bank switching.

Parameters:
WORD_BITS, 32, data word width
REG_ADDR_BITS, 5, register address width
NUM_OF_REG, 32, number of architectural registers (2**REG_ADDR_BITS)
LD_FIFO_DEPTH, 4, load-result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive ALU-won cycles before a forced load drain

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
iAluValid  in  1  ALU result present
iAluAddr  in  REG_ADDR_BITS  ALU destination register
iAluVal  in  WORD_BITS  ALU result
oAluStall  out  1  ALU result not consumed this cycle; ALU holds inputs
iLdValid  in  1  load result present
oLdReady  out  1  load FIFO can accept
iLdAddr  in  REG_ADDR_BITS  load destination register
iLdVal  in  WORD_BITS  load data
oDstAddr  out  REG_ADDR_BITS  register-file write address
oDstVal  out  WORD_BITS  register-file write data
oDstValid  out  1  register-file write enable
oBusyMask  out  NUM_OF_REG  bit n = write to register n pending
oIdle  out  1  FIFO empty and no write in output stage

Behaviour:
- Reset:
  - Any edge with rst=0 empties the FIFO (pointers and count = 0) and clears the starve counter.
  - oDstValid=0, oDstAddr=0, oDstVal=0.
  - While rst=0: oLdReady=0, oAluStall=0. oBusyMask=0 and oIdle=1 after the reset edge.
  - Reset mid-operation discards queued loads and any in-flight output write with no partial write.
- Load accept:
  - oLdReady = rst & (count < LD_FIFO_DEPTH). It is low when full even if a pop occurs in the same cycle (no push-through-pop).
  - Handshake completes when iLdValid & oLdReady at an edge.
  - Address 0 is accepted but never enqueued (count unchanged).
- Port selection, evaluated each cycle:
  - force = (FIFO nonempty) & (starve_cnt == STARVE_LIMIT).
  - If force: pop the FIFO head and assert oAluStall = iAluValid. The ALU result is not consumed.
  - Else if iAluValid: the ALU wins and the FIFO does not pop. iAluAddr==0 is consumed but produces no write.
  - Else if FIFO nonempty: pop the head.
  - Else: no write.
- Output stage: registered. The selected address and value appear on oDstAddr/oDstVal with oDstValid=1 on the cycle after the selection edge, giving latency 1 from selection. A load accepted at edge k is written (oDstValid high) in cycle k+1 at the earliest.
- Starve counter:
  - Increments when the FIFO is nonempty and the ALU wins, saturating at STARVE_LIMIT.
  - Clears on any FIFO pop or when the FIFO is empty.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo LD_FIFO_DEPTH.
- oBusyMask (combinational) = OR of one-hot(addr) over valid FIFO entries | one-hot(oDstAddr) when oDstValid. Bit 0 is always 0.
- oIdle = (count==0) & ~oDstValid. The bank-switch controller may toggle the register-file shadow select only while oIdle=1.
- Write ordering to the same register follows selection order, so the last selected write wins.

Test Plan:
- Reset: hold rst=0 for 3 cycles with iLdValid=1 -> oLdReady=0, oDstValid=0, oBusyMask=0, oIdle=1. Release -> oLdReady=1.
- ALU only: iAluValid=1, addr 5, val 0x1234 for one cycle -> next cycle oDstValid=1, oDstAddr=5, oDstVal=0x1234, oBusyMask[5]=1. The cycle after that, oIdle=1.
- Load fill: 5 loads to r1..r5 with ALU busy every cycle -> first 4 accepted, oLdReady=0 on the 5th, oBusyMask bits 1..4 set. Drop iAluValid -> writes r1,r2,r3,r4 in order on consecutive cycles, then oLdReady=1.
- Starvation: one queued load to r7, iAluValid held 1 continuously -> after 8 ALU writes, oAluStall=1 for one cycle. Next cycle oDstAddr=7. ALU data held during stall is written on the following cycle.
- Address 0: ALU addr 0 and load addr 0 with val 0xFFFF -> both handshake, oDstValid never asserts, count stays 0.
- Mid-operation reset: 3 loads queued, assert rst=0 for one cycle -> FIFO empty, oDstValid=0, oBusyMask=0. None of the queued loads is ever written.
